hwag_tooth_meter: RTL and testbench

HWAG_TOOTH_METER -- requirements
Module: hwag_tooth_meter

---
 rtl/hwag_pkg.sv | 18 +
 rtl/hwag_period_cnt.sv | 28 ++
 rtl/hwag_tooth_meter.sv | 158 +++++++++++++++
 tb/tb_hwag_tooth_meter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hwag_pkg.sv
// Shared types for the HWAG crank-wheel tooth meter: FSM state codes and
// gap-threshold selector codes.
package hwag_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FIRST = 3'd1,
    ST_PRIME = 3'd2,
    ST_HUNT  = 3'd3,
    ST_SYNC  = 3'd4
  } hwag_state_e;

  localparam logic [1:0] GAP_1P5 = 2'd0;
  localparam logic [1:0] GAP_2X  = 2'd1;
  localparam logic [1:0] GAP_2P5 = 2'd2;
  localparam logic [1:0] GAP_3X  = 2'd3;

endpackage

// File: rtl/hwag_period_cnt.sv
// Saturating cycle counter measuring time since the last accepted tooth edge.
// load clears to zero; run lets it count up until it sticks at all-ones.
module hwag_period_cnt #(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             run,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  assign sat = (cnt == CNT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (run && !sat) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hwag_tooth_meter.sv
// Tooth period meter and missing-tooth gap synchroniser for a VR crank wheel.
// All outputs are registered; events show up one cycle after the edge_in cycle.
module hwag_tooth_meter
  import hwag_pkg::*;
#(
  parameter int CNT_W   = 24,
  parameter int TOOTH_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic               edge_in,
  input  logic [TOOTH_W-1:0] teeth_total,
  input  logic [1:0]         gap_sel,
  output logic [CNT_W-1:0]   period_cur,
  output logic [CNT_W-1:0]   period_prev,
  output logic [TOOTH_W-1:0] tooth_num,
  output logic               synced,
  output logic               tooth_pulse,
  output logic               gap_pulse,
  output logic               sync_err,
  output logic               stall,
  output logic [2:0]         state
);

  hwag_state_e        state_q, state_d;
  logic [CNT_W-1:0]   cnt;
  logic               cnt_sat, cnt_load, cnt_run;
  logic [CNT_W-1:0]   p_new, period_cur_d, period_prev_d;
  logic [CNT_W+1:0]   gap_thr;
  logic [TOOTH_W-1:0] tooth_d;
  logic               is_gap, last_tooth, capture;
  logic               synced_d, tooth_pulse_d, gap_pulse_d, sync_err_d, stall_d;

  // Threshold is a multiple of the period preceding the one being measured;
  // two extra bits so 3x never wraps.
  function automatic logic [CNT_W+1:0] gap_threshold(input logic [CNT_W-1:0] p,
                                                     input logic [1:0]       sel);
    logic [CNT_W+1:0] pw;
    logic [CNT_W+1:0] thr;
    pw  = {2'b00, p};
    thr = '0;
    case (sel)
      GAP_1P5: thr = pw + (pw >> 1);
      GAP_2X:  thr = pw << 1;
      GAP_2P5: thr = (pw << 1) + (pw >> 1);
      GAP_3X:  thr = (pw << 1) + pw;
    endcase
    return thr;
  endfunction

  assign cnt_load = !ena || (state_q == ST_IDLE) || edge_in;
  assign cnt_run  = (state_q != ST_IDLE);

  hwag_period_cnt #(.CNT_W(CNT_W)) u_period_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (cnt_load),
    .run  (cnt_run),
    .cnt  (cnt),
    .sat  (cnt_sat)
  );

  always_comb begin
    state_d       = state_q;
    period_cur_d  = period_cur;
    period_prev_d = period_prev;
    tooth_d       = tooth_num;
    tooth_pulse_d = 1'b0;
    gap_pulse_d   = 1'b0;
    sync_err_d    = 1'b0;
    stall_d       = 1'b0;
    capture       = 1'b0;

    // An edge landing on a saturated counter still counts, reported as the max period.
    p_new      = cnt_sat ? cnt : cnt + CNT_W'(1);
    gap_thr    = gap_threshold(period_cur, gap_sel);
    is_gap     = ({2'b00, p_new} >= gap_thr);
    last_tooth = (tooth_num == teeth_total - TOOTH_W'(1));

    if (!ena) begin
      state_d       = ST_IDLE;
      period_cur_d  = '0;
      period_prev_d = '0;
      tooth_d       = '0;
    end else if (state_q == ST_IDLE) begin
      state_d = ST_FIRST;
    end else if (edge_in) begin
      case (state_q)
        ST_FIRST: state_d = ST_PRIME;
        ST_PRIME: begin
          state_d = ST_HUNT;
          capture = 1'b1;
        end
        ST_HUNT: begin
          capture = 1'b1;
          if (is_gap) begin
            state_d     = ST_SYNC;
            tooth_d     = '0;
            gap_pulse_d = 1'b1;
          end
        end
        ST_SYNC: begin
          capture = 1'b1;
          if (is_gap && last_tooth) begin
            tooth_d     = '0;
            gap_pulse_d = 1'b1;
          end else if (is_gap || last_tooth) begin
            state_d    = ST_HUNT;
            tooth_d    = '0;
            sync_err_d = 1'b1;
          end else begin
            tooth_d       = tooth_num + TOOTH_W'(1);
            tooth_pulse_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (cnt_sat) begin
      state_d = ST_IDLE;
      tooth_d = '0;
      stall_d = 1'b1;
    end

    if (capture) begin
      period_prev_d = period_cur;
      period_cur_d  = p_new;
    end
    synced_d = (state_d == ST_SYNC);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      period_cur  <= '0;
      period_prev <= '0;
      tooth_num   <= '0;
      synced      <= 1'b0;
      tooth_pulse <= 1'b0;
      gap_pulse   <= 1'b0;
      sync_err    <= 1'b0;
      stall       <= 1'b0;
    end else begin
      state_q     <= state_d;
      period_cur  <= period_cur_d;
      period_prev <= period_prev_d;
      tooth_num   <= tooth_d;
      synced      <= synced_d;
      tooth_pulse <= tooth_pulse_d;
      gap_pulse   <= gap_pulse_d;
      sync_err    <= sync_err_d;
      stall       <= stall_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_hwag_tooth_meter.sv
// Bench for hwag_tooth_meter: directed vector table, wheel sequences, ena/rst
// corner cases, an 8-bit-counter stall run and randomized revolutions.
module tb_hwag_tooth_meter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ena = 1'b0;
  logic        edge_in = 1'b0;
  logic [7:0]  teeth_total = 8'd58;
  logic [1:0]  gap_sel = 2'd1;

  logic [23:0] period_cur, period_prev;
  logic [7:0]  tooth_num;
  logic        synced, tooth_pulse, gap_pulse, sync_err, stall;
  logic [2:0]  state;

  logic [7:0]  s8_period_cur, s8_period_prev, s8_tooth_num;
  logic        s8_synced, s8_tooth_pulse, s8_gap_pulse, s8_sync_err, s8_stall;
  logic [2:0]  s8_state;

  logic [63:0] dut_vec;
  logic [63:0] exp_q[$];

  int n_cmp = 0;
  int n_fail = 0;
  int obs_gap = 0;
  int obs_err = 0;

  // behavioural model state, per accepted edge
  int     m_edges;
  bit     m_locked;
  int     m_idx;
  longint m_pcur, m_pprev;

  typedef struct {
    logic [1:0]  sel;
    int          p;
    logic [2:0]  st;
    logic [7:0]  tn;
    logic        gp;
    logic        se;
    logic [23:0] pc;
    logic [23:0] pp;
  } vec_t;

  vec_t vecs[17];

  hwag_tooth_meter #(.CNT_W(24), .TOOTH_W(8)) dut (
    .clk(clk), .rst(rst), .ena(ena), .edge_in(edge_in),
    .teeth_total(teeth_total), .gap_sel(gap_sel),
    .period_cur(period_cur), .period_prev(period_prev), .tooth_num(tooth_num),
    .synced(synced), .tooth_pulse(tooth_pulse), .gap_pulse(gap_pulse),
    .sync_err(sync_err), .stall(stall), .state(state)
  );

  hwag_tooth_meter #(.CNT_W(8), .TOOTH_W(8)) dut8 (
    .clk(clk), .rst(rst), .ena(ena), .edge_in(edge_in),
    .teeth_total(teeth_total), .gap_sel(gap_sel),
    .period_cur(s8_period_cur), .period_prev(s8_period_prev), .tooth_num(s8_tooth_num),
    .synced(s8_synced), .tooth_pulse(s8_tooth_pulse), .gap_pulse(s8_gap_pulse),
    .sync_err(s8_sync_err), .stall(s8_stall), .state(s8_state)
  );

  assign dut_vec = {state, synced, tooth_pulse, gap_pulse, sync_err, stall,
                    tooth_num, period_cur, period_prev};

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_edges  = 0;
    m_locked = 0;
    m_idx    = 0;
    m_pcur   = 0;
    m_pprev  = 0;
    exp_q.delete();
  endfunction

  // Expected outcome of one accepted edge whose spacing from the previous one is p.
  function automatic void model_edge(input int p);
    bit         gap;
    logic       tp, gp, se;
    logic [2:0] st;
    longint     thr;
    tp  = 1'b0;
    gp  = 1'b0;
    se  = 1'b0;
    thr = ((longint'(gap_sel) + 3) * m_pcur) / 2;
    gap = (m_edges >= 2) && (longint'(p) >= thr);
    if (m_edges >= 2) begin
      if (!m_locked) begin
        if (gap) begin
          m_locked = 1;
          m_idx    = 0;
          gp       = 1'b1;
        end
      end else if (gap && m_idx == int'(teeth_total) - 1) begin
        m_idx = 0;
        gp    = 1'b1;
      end else if (gap || m_idx == int'(teeth_total) - 1) begin
        m_locked = 0;
        m_idx    = 0;
        se       = 1'b1;
      end else begin
        m_idx++;
        tp = 1'b1;
      end
    end
    if (m_edges >= 1) begin
      m_pprev = m_pcur;
      m_pcur  = p;
    end
    m_edges++;
    st = (m_edges == 1) ? 3'd2 : (m_locked ? 3'd4 : 3'd3);
    exp_q.push_back({st, m_locked, tp, gp, se, 1'b0, 8'(m_idx), 24'(m_pcur), 24'(m_pprev)});
  endfunction

  // Edge p cycles after the previous one; returns at active edge + 1 with outputs sampled.
  task automatic send_edge(input int p);
    logic [63:0] e;
    for (int i = 0; i < p - 1; i++) begin
      @(negedge clk);
      edge_in = 1'b0;
      if (i == 1) check("pulse_clear", {tooth_pulse, gap_pulse, sync_err, stall}, 4'b0000);
    end
    @(negedge clk);
    edge_in = 1'b1;
    model_edge(p);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("edge", dut_vec, e);
    obs_gap += int'(gap_pulse);
    obs_err += int'(sync_err);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    edge_in = 1'b0;
    ena = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("arm_first", state, 3'd1);
    model_reset();
  endtask

  initial begin
    int stall_at, n_stall;

    vecs[0]  = '{2'd0,   5, 3'd2, 8'd0, 1'b0, 1'b0, 24'd0,   24'd0};
    vecs[1]  = '{2'd0, 100, 3'd3, 8'd0, 1'b0, 1'b0, 24'd100, 24'd0};
    vecs[2]  = '{2'd0, 149, 3'd3, 8'd0, 1'b0, 1'b0, 24'd149, 24'd100};
    vecs[3]  = '{2'd0, 100, 3'd3, 8'd0, 1'b0, 1'b0, 24'd100, 24'd149};
    vecs[4]  = '{2'd0, 150, 3'd4, 8'd0, 1'b1, 1'b0, 24'd150, 24'd100};
    vecs[5]  = '{2'd3, 100, 3'd4, 8'd1, 1'b0, 1'b0, 24'd100, 24'd150};
    vecs[6]  = '{2'd3, 299, 3'd4, 8'd2, 1'b0, 1'b0, 24'd299, 24'd100};
    vecs[7]  = '{2'd3, 100, 3'd4, 8'd3, 1'b0, 1'b0, 24'd100, 24'd299};
    vecs[8]  = '{2'd3, 300, 3'd3, 8'd0, 1'b0, 1'b1, 24'd300, 24'd100};
    vecs[9]  = '{2'd2, 100, 3'd3, 8'd0, 1'b0, 1'b0, 24'd100, 24'd300};
    vecs[10] = '{2'd2, 249, 3'd3, 8'd0, 1'b0, 1'b0, 24'd249, 24'd100};
    vecs[11] = '{2'd2, 100, 3'd3, 8'd0, 1'b0, 1'b0, 24'd100, 24'd249};
    vecs[12] = '{2'd2, 250, 3'd4, 8'd0, 1'b1, 1'b0, 24'd250, 24'd100};
    vecs[13] = '{2'd1, 100, 3'd4, 8'd1, 1'b0, 1'b0, 24'd100, 24'd250};
    vecs[14] = '{2'd1, 199, 3'd4, 8'd2, 1'b0, 1'b0, 24'd199, 24'd100};
    vecs[15] = '{2'd1, 100, 3'd4, 8'd3, 1'b0, 1'b0, 24'd100, 24'd199};
    vecs[16] = '{2'd1, 200, 3'd3, 8'd0, 1'b0, 1'b1, 24'd200, 24'd100};

    // reset state
    #12;
    check("reset_vec", dut_vec, 64'd0);
    check("reset_vec8", {s8_state, s8_synced, s8_stall, s8_tooth_num, s8_period_cur}, 32'd0);

    // directed thresholds for every gap_sel, including exact-boundary periods
    teeth_total = 8'd200;
    do_reset();
    foreach (vecs[k]) begin
      gap_sel = vecs[k].sel;
      send_edge(vecs[k].p);
      check("tbl_state", state, vecs[k].st);
      check("tbl_tooth", tooth_num, vecs[k].tn);
      check("tbl_gap", gap_pulse, vecs[k].gp);
      check("tbl_err", sync_err, vecs[k].se);
      check("tbl_pcur", period_cur, vecs[k].pc);
      check("tbl_pprev", period_prev, vecs[k].pp);
    end

    // 60-2 wheel: lock, two clean revolutions, then one extra tooth
    teeth_total = 8'd58;
    gap_sel = 2'd1;
    do_reset();
    obs_gap = 0;
    obs_err = 0;
    send_edge(50);
    send_edge(100);
    repeat (3) send_edge(100);
    send_edge(300);
    check("wheel_synced", synced, 1'b1);
    for (int r = 0; r < 2; r++) begin
      for (int t = 0; t < 57; t++) send_edge(100);
      check("wheel_last_tooth", tooth_num, 8'd57);
      send_edge(300);
      check("wheel_wrap", tooth_num, 8'd0);
    end
    check("wheel_gap_count", obs_gap, 3);
    check("wheel_no_err", obs_err, 0);
    for (int t = 0; t < 58; t++) send_edge(100);
    check("extra_err", obs_err, 1);
    check("extra_state_hunt", state, 3'd3);
    check("extra_unsynced", synced, 1'b0);
    send_edge(100);
    send_edge(300);
    check("extra_resync", state, 3'd4);
    check("extra_gap_count", obs_gap, 4);

    // ena falls in SYNC together with an edge
    @(negedge clk);
    ena = 1'b0;
    edge_in = 1'b1;
    @(posedge clk);
    #1;
    check("ena_drop", dut_vec, 64'd0);
    @(negedge clk);
    edge_in = 1'b0;
    @(posedge clk);
    #1;
    check("ena_low_hold", dut_vec, 64'd0);
    @(negedge clk);
    ena = 1'b1;
    @(posedge clk);
    #1;
    check("ena_rearm", state, 3'd1);
    model_reset();
    send_edge(20);
    send_edge(100);
    send_edge(100);
    send_edge(300);
    check("ena_resync", synced, 1'b1);

    // asynchronous reset in the middle of a revolution
    send_edge(100);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("rst_async", dut_vec, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    edge_in = 1'b0;
    @(posedge clk);
    #1;
    check("rst_first", state, 3'd1);
    model_reset();
    send_edge(40);
    check("rst_prime", state, 3'd2);
    send_edge(100);
    check("rst_hunt", state, 3'd3);
    send_edge(100);
    send_edge(300);
    check("rst_resync", state, 3'd4);

    // 8-bit counter: lock on a short wheel, then stop edges until it stalls
    teeth_total = 8'd4;
    gap_sel = 2'd1;
    do_reset();
    send_edge(5);
    send_edge(10);
    send_edge(10);
    send_edge(30);
    repeat (3) send_edge(10);
    send_edge(30);
    check("s8_synced", s8_synced, 1'b1);
    n_stall = 0;
    stall_at = 0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      edge_in = 1'b0;
      @(posedge clk);
      #1;
      if (s8_stall) begin
        n_stall++;
        stall_at = c;
        check("s8_stall_idle", s8_state, 3'd0);
        check("s8_stall_unsynced", s8_synced, 1'b0);
      end
    end
    check("s8_stall_count", n_stall, 1);
    check("s8_stall_cycle", stall_at, 256);
    check("s8_rearm", s8_state, 3'd1);
    check("main_no_stall", stall, 1'b0);

    // randomized revolutions, occasionally one tooth short or long
    teeth_total = 8'd8;
    gap_sel = 2'd1;
    do_reset();
    send_edge(30);
    send_edge(30);
    for (int r = 0; r < 12; r++) begin
      int n, k;
      n = int'($urandom_range(20, 40));
      teeth_total = 8'($urandom_range(3, 12));
      gap_sel = 2'($urandom_range(0, 3));
      k = int'(teeth_total) - 1;
      if ($urandom_range(0, 3) == 0) k = k + (($urandom_range(0, 1) == 1) ? 1 : -1);
      for (int t = 0; t < k; t++) send_edge(n + int'($urandom_range(0, 4)) - 2);
      send_edge(4 * n);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
